// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-file write port between ALU and MEM and keeps busy bits for RAW/WAW stalls.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; the default build gives MEM fixed priority over ALU.
module regfile_wb_scheduler #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [ADDR_W-1:0]       alu_rd,
    input  logic [DATA_W-1:0]       alu_data,
    output logic                    alu_ready,
    input  logic                    mem_valid,
    input  logic [ADDR_W-1:0]       mem_rd,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    mem_ready,
    input  logic                    issue_valid,
    input  logic [ADDR_W-1:0]       issue_rd,
    input  logic [ADDR_W-1:0]       issue_rs1,
    input  logic [ADDR_W-1:0]       issue_rs2,
    output logic                    issue_stall,
    output logic                    RegWrite,
    output logic [ADDR_W-1:0]       rd,
    output logic [DATA_W-1:0]       WriteData,
    output logic [(2**ADDR_W)-1:0]  busy_vec,
    output logic                    wb_err
);
    localparam int NREG = 2**ADDR_W;

    logic              grant_alu, grant_mem, accept;
    logic [ADDR_W-1:0] acc_rd;
    logic [DATA_W-1:0] acc_data;
    logic              stall, issue_accept;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wb_err_q, wb_err_d;

`ifdef WB_ROUND_ROBIN_EN
    logic rr_q, rr_d;  // 1: MEM wins the next tie

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (reset) begin
            if (alu_valid && mem_valid) begin
                grant_mem = rr_q;
                grant_alu = !rr_q;
            end else begin
                grant_mem = mem_valid;
                grant_alu = alu_valid;
            end
        end
        rr_d = rr_q;
        if (grant_alu)
            rr_d = 1'b1;
        else if (grant_mem)
            rr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_q <= 1'b0;
        else
            rr_q <= rr_d;
    end
`else
    always_comb begin
        grant_mem = reset & mem_valid;
        grant_alu = reset & alu_valid & !mem_valid;
    end
`endif

    always_comb begin
        accept       = grant_alu | grant_mem;
        acc_rd       = grant_mem ? mem_rd   : alu_rd;
        acc_data     = grant_mem ? mem_data : alu_data;
        stall        = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
        issue_accept = issue_valid & !stall & (issue_rd != '0);

        regwrite_d = accept & (acc_rd != '0);
        rd_d       = accept ? acc_rd   : rd_q;
        wdata_d    = accept ? acc_data : wdata_q;
        wb_err_d   = wb_err_q | (regwrite_d & !busy_q[acc_rd]);

        // Clear first so a same-index set would win.
        busy_d = busy_q;
        if (regwrite_q)
            busy_d[rd_q] = 1'b0;
        if (issue_accept)
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign alu_ready   = grant_alu;
    assign mem_ready   = grant_mem;
    assign issue_stall = stall;
    assign RegWrite    = regwrite_q;
    assign rd          = rd_q;
    assign WriteData   = wdata_q;
    assign busy_vec    = busy_q;
    assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: combinational vector table, directed corner sequences, and random traffic against a model.
`timescale 1ns/1ps
module tb_regfile_wb_scheduler;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0, reset = 1'b0, clk_en = 1'b1;
    logic          alu_valid = 0, mem_valid = 0, issue_valid = 0;
    logic [AW-1:0] alu_rd = 0, mem_rd = 0, issue_rd = 0, issue_rs1 = 0, issue_rs2 = 0;
    logic [DW-1:0] alu_data = 0, mem_data = 0;
    logic          alu_ready, mem_ready, issue_stall, RegWrite, wb_err;
    logic [AW-1:0] rd;
    logic [DW-1:0] WriteData;
    logic [NR-1:0] busy_vec;
    int total = 0, bad = 0;

    regfile_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_stall(issue_stall), .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData),
        .busy_vec(busy_vec), .wb_err(wb_err)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Reference model: busy set, pending write-port contents, sticky error, last winner.
    bit [NR-1:0] m_busy;
    bit          m_we, m_err, m_last_mem;
    bit [AW-1:0] m_rd;
    bit [DW-1:0] m_data;

    function automatic void m_reset();
        m_busy = '0; m_we = 0; m_err = 0; m_rd = '0; m_data = '0; m_last_mem = 1;
    endfunction

    function automatic int m_grant();  // 0 none, 1 ALU, 2 MEM
        if (!reset) return 0;
        if (alu_valid && mem_valid) begin
`ifdef WB_ROUND_ROBIN_EN
            return m_last_mem ? 1 : 2;
`else
            return 2;
`endif
        end
        if (mem_valid) return 2;
        if (alu_valid) return 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        if (!issue_valid) return 0;
        return (issue_rs1 != 0 && m_busy[issue_rs1]) || (issue_rs2 != 0 && m_busy[issue_rs2]) ||
               (issue_rd != 0 && m_busy[issue_rd]);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    endtask

    // Called just after a falling edge with inputs applied; checks, then advances the model one clock.
    task automatic cycle();
        int g; bit st; bit [NR-1:0] nb; logic [AW-1:0] wr; logic [DW-1:0] wd;
        #1;
        g  = m_grant();
        st = m_stall();
        chk("alu_ready",   64'(alu_ready),   64'(g == 1));
        chk("mem_ready",   64'(mem_ready),   64'(g == 2));
        chk("issue_stall", 64'(issue_stall), 64'(st));
        chk("RegWrite",    64'(RegWrite),    64'(m_we));
        chk("rd",          64'(rd),          64'(m_rd));
        chk("WriteData",   WriteData,        m_data);
        chk("busy_vec",    64'(busy_vec),    64'(m_busy));
        chk("wb_err",      64'(wb_err),      64'(m_err));
        wr = (g == 2) ? mem_rd : alu_rd;
        wd = (g == 2) ? mem_data : alu_data;
        nb = m_busy;
        if (m_we) nb[m_rd] = 0;
        if (issue_valid && !st && issue_rd != 0) nb[issue_rd] = 1;
        @(posedge clk);
        if (g != 0) begin
            if (wr != 0 && !m_busy[wr]) m_err = 1;
            m_we = (wr != 0); m_rd = wr; m_data = wd; m_last_mem = (g == 2);
        end else begin
            m_we = 0;
        end
        m_busy = nb;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic issue(input logic [AW-1:0] d);
        issue_valid = 1; issue_rd = d; issue_rs1 = 0; issue_rs2 = 0;
        cycle();
        issue_valid = 0;
    endtask

    function automatic logic [AW-1:0] pick_rd();
        int s;
        s = $urandom_range(0, NR-1);
        if ($urandom_range(0, 7) != 0)
            for (int i = 0; i < NR; i++)
                if (m_busy[(s + i) % NR]) return AW'((s + i) % NR);
        return AW'($urandom_range(0, NR-1));
    endfunction

    typedef struct {
        logic av; logic [AW-1:0] ard; logic mv; logic [AW-1:0] mrd;
        logic iv; logic [AW-1:0] ird, rs1, rs2;
        logic e_ar, e_mr, e_st;
    } vec_t;
    vec_t vt[10];

    initial begin
        logic both_alu;
        int g;
        both_alu = 0;
`ifdef WB_ROUND_ROBIN_EN
        both_alu = 1;
`endif
        vt[0] = '{0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0};
        vt[1] = '{1, 5, 0, 0,  0, 0, 0, 0,   1, 0, 0};
        vt[2] = '{0, 0, 1, 12, 0, 0, 0, 0,   0, 1, 0};
        vt[3] = '{1, 5, 1, 12, 0, 0, 0, 0,   both_alu, !both_alu, 0};
        vt[4] = '{0, 0, 0, 0,  1, 1, 5, 0,   0, 0, 1};
        vt[5] = '{0, 0, 0, 0,  1, 1, 0, 12,  0, 0, 1};
        vt[6] = '{0, 0, 0, 0,  1, 5, 0, 0,   0, 0, 1};
        vt[7] = '{0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 0};
        vt[8] = '{0, 0, 0, 0,  0, 1, 5, 12,  0, 0, 0};
        vt[9] = '{0, 0, 0, 0,  1, 6, 7, 13,  0, 0, 0};

        // Reset with every request active
        m_reset();
        reset = 0;
        alu_valid = 1; alu_rd = 3; alu_data = 64'h33;
        mem_valid = 1; mem_rd = 4; mem_data = 64'h44;
        issue_valid = 1; issue_rd = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_alu_ready", 64'(alu_ready), 0);
            chk("rst_mem_ready", 64'(mem_ready), 0);
            chk("rst_RegWrite",  64'(RegWrite),  0);
            chk("rst_busy_vec",  64'(busy_vec),  0);
            chk("rst_wb_err",    64'(wb_err),    0);
        end
        @(negedge clk);
        idle();
        reset = 1;
        @(negedge clk);

        // Combinational table with busy = {5,12}, clock parked low
        issue(5);
        issue(12);
        clk_en = 0;
        foreach (vt[i]) begin
            alu_valid = vt[i].av; alu_rd = vt[i].ard; mem_valid = vt[i].mv; mem_rd = vt[i].mrd;
            issue_valid = vt[i].iv; issue_rd = vt[i].ird; issue_rs1 = vt[i].rs1; issue_rs2 = vt[i].rs2;
            #1;
            chk($sformatf("vec%0d_alu_ready", i),   64'(alu_ready),   64'(vt[i].e_ar));
            chk($sformatf("vec%0d_mem_ready", i),   64'(mem_ready),   64'(vt[i].e_mr));
            chk($sformatf("vec%0d_issue_stall", i), 64'(issue_stall), 64'(vt[i].e_st));
        end
        idle();
        #1;
        clk_en = 1;
        @(negedge clk);

        // RAW hazard on x5
        do_reset();
        issue(5);
        issue_valid = 1; issue_rd = 0; issue_rs1 = 5;
        #1 chk("raw_stall_before", 64'(issue_stall), 1);
        cycle();
        alu_valid = 1; alu_rd = 5; alu_data = 64'hA5;
        cycle();
        alu_valid = 0;
        #1;
        chk("raw_RegWrite", 64'(RegWrite), 1);
        chk("raw_rd", 64'(rd), 5);
        chk("raw_WriteData", WriteData, 64'hA5);
        chk("raw_stall_during_wb", 64'(issue_stall), 1);
        cycle();
        #1 chk("raw_stall_after", 64'(issue_stall), 0);
        cycle();
        idle();

        // Simultaneous ALU rd=3 and MEM rd=4
        do_reset();
        issue(3);
        issue(4);
        alu_valid = 1; alu_rd = 3; alu_data = 64'h33;
        mem_valid = 1; mem_rd = 4; mem_data = 64'h44;
        g = m_grant();
        cycle();
        if (g == 1) alu_valid = 0; else mem_valid = 0;
        #1 chk("sim_first_rd", 64'(rd), both_alu ? 3 : 4);
        cycle();
        idle();
        #1 chk("sim_second_rd", 64'(rd), both_alu ? 4 : 3);
        cycle();
        cycle();
        chk("sim_busy_clear", 64'(busy_vec), 0);

        // Write to x0
        do_reset();
        alu_valid = 1; alu_rd = 0; alu_data = 64'hFF;
        issue_valid = 1; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        #1;
        chk("x0_alu_ready", 64'(alu_ready), 1);
        chk("x0_stall", 64'(issue_stall), 0);
        cycle();
        idle();
        #1;
        chk("x0_RegWrite", 64'(RegWrite), 0);
        chk("x0_wb_err", 64'(wb_err), 0);
        cycle();

        // Unexpected MEM write to non-busy x9
        do_reset();
        mem_valid = 1; mem_rd = 9; mem_data = 64'h99;
        cycle();
        mem_valid = 0;
        #1;
        chk("unexp_RegWrite", 64'(RegWrite), 1);
        chk("unexp_rd", 64'(rd), 9);
        chk("unexp_wb_err", 64'(wb_err), 1);
        repeat (3) cycle();
        chk("unexp_wb_err_sticky", 64'(wb_err), 1);

        // Reset lands between an accept and its write-back edge
        do_reset();
        issue(7);
        alu_valid = 1; alu_rd = 7; alu_data = 64'h77;
        #1 chk("midrst_accept", 64'(alu_ready), 1);
        chk("midrst_busy7", 64'(busy_vec[7]), 1);
        #1 reset = 0;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst_RegWrite", 64'(RegWrite), 0);
        chk("midrst_busy_vec", 64'(busy_vec), 0);
        idle();
        reset = 1;
        @(negedge clk);

        // Random traffic; losers hold their request until granted
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                if (!alu_valid && $urandom_range(0, 2) == 0) begin
                    alu_valid = 1; alu_rd = pick_rd(); alu_data = {$urandom, $urandom};
                end
                if (!mem_valid && $urandom_range(0, 2) == 0) begin
                    mem_valid = 1; mem_rd = pick_rd(); mem_data = {$urandom, $urandom};
                end
                issue_valid = 1'($urandom_range(0, 1));
                issue_rd  = AW'($urandom);
                issue_rs1 = AW'($urandom);
                issue_rs2 = AW'($urandom);
                g = m_grant();
                cycle();
                if (g == 1) alu_valid = 0;
                if (g == 2) mem_valid = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
